// File: rtl/antares_muldiv_unit.sv
// antares_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair,
// radix-configurable shift-add multiply with accumulate, restoring divide.
module antares_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] md_operand_a,
    input  logic [WIDTH-1:0] md_operand_b,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_div_by_zero,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);
    localparam int N  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_MADD = 4'd3, OP_MADDU = 4'd4,
                           OP_DIV = 4'd7, OP_DIVU = 4'd8, OP_MTHI = 4'd9, OP_MTLO = 4'd10;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;
    state_t state, state_nx;
    logic [3:0] op;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, b_r, a_mag, b_mag, q_fix, r_fix;
    logic [2*WIDTH-1:0] acc, mcand, part, prod, mul_res, fin;
    logic [WIDTH:0] shl, diff;
    logic neg_q, neg_r, done, dbz, accept, is_mul, is_div, sgn, b_zero, fin_div;
    assign accept = md_start && !md_flush && state == IDLE;
    assign is_mul = md_op >= OP_MULT && md_op <= 4'd6;
    assign is_div = md_op == OP_DIV || md_op == OP_DIVU;
    assign sgn    = md_op == OP_MULT || md_op == OP_MADD || md_op == 4'd5 || md_op == OP_DIV;
    assign b_zero = md_operand_b == '0;
    assign a_mag  = sgn && md_operand_a[WIDTH-1] ? -md_operand_a : md_operand_a;
    assign b_mag  = sgn && md_operand_b[WIDTH-1] ? -md_operand_b : md_operand_b;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        if (md_flush) state_nx = IDLE;
        else if (state == IDLE) state_nx = accept && is_mul ? MUL : accept && is_div && !b_zero ? DIV : IDLE;
        else if (state == FINISH) state_nx = IDLE;
        else if (cnt == CW'(1)) state_nx = FINISH;
    end
    always_comb begin
        md_busy = state != IDLE;
        part = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (b_r[i]) part = part + (mcand << i);
        // remainder and next dividend bit sit side by side in acc
        shl = acc[2*WIDTH-1:WIDTH-1];
        diff = shl - {1'b0, b_r};
        prod = neg_q ? -acc : acc;
        mul_res = op == OP_MULT || op == OP_MULTU ? prod :
                  op == OP_MADD || op == OP_MADDU ? {hi, lo} + prod : {hi, lo} - prod;
        q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fin_div = op == OP_DIV || op == OP_DIVU;
        fin = fin_div ? {r_fix, q_fix} : mul_res;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op <= '0;
            cnt <= '0;
            hi <= '0;
            lo <= '0;
            b_r <= '0;
            acc <= '0;
            mcand <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            done <= 1'b0;
            dbz <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz <= 1'b0;
            if (accept) begin
                op <= md_op;
                neg_q <= sgn && (md_operand_a[WIDTH-1] ^ md_operand_b[WIDTH-1]);
                neg_r <= sgn && md_operand_a[WIDTH-1];
                mcand <= {{WIDTH{1'b0}}, a_mag};
                b_r <= b_mag;
                cnt <= is_div ? CW'(WIDTH) : CW'(N);
                acc <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                if (md_op == OP_MTHI) hi <= md_operand_a;
                if (md_op == OP_MTLO) lo <= md_operand_a;
                if (is_div && b_zero) begin
                    done <= 1'b1;
                    dbz <= 1'b1;
                end
            end else if (!md_flush) begin
                if (state == MUL) begin
                    acc <= acc + part;
                    mcand <= mcand << MUL_STEP;
                    b_r <= b_r >> MUL_STEP;
                    cnt <= cnt - CW'(1);
                end
                if (state == DIV) begin
                    acc <= {diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]};
                    cnt <= cnt - CW'(1);
                end
                if (state == FINISH) begin
                    {hi, lo} <= fin;
                    done <= 1'b1;
                end
            end
        end
    assign md_done = done;
    assign md_div_by_zero = dbz;
    assign md_hi = hi;
    assign md_lo = lo;
endmodule

// File: tb/tb_antares_muldiv_unit.sv
// tb_antares_muldiv_unit: directed plus random ops checked against a
// plain-arithmetic HI/LO model.
module tb_antares_muldiv_unit;
    logic clk = 1'b0, rst = 1'b1, md_start = 1'b0, md_flush = 1'b0;
    logic [3:0] md_op = '0;
    logic [31:0] md_operand_a = '0, md_operand_b = '0;
    logic md_busy, md_done, md_div_by_zero;
    logic [31:0] md_hi, md_lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int errors = 0, checks = 0;
    antares_muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b), .md_flush(md_flush),
        .md_busy(md_busy), .md_done(md_done), .md_div_by_zero(md_div_by_zero),
        .md_hi(md_hi), .md_lo(md_lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_start = 1'b1;
        md_op = op;
        md_operand_a = a;
        md_operand_b = b;
        @(negedge clk);
        md_start = 1'b0;
    endtask
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, hl, e;
        int lat, busy_n, exp_lat;
        logic exp_dbz;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hl = {m_hi, m_lo};
        e = hl;
        exp_lat = -1;
        exp_dbz = 1'b0;
        case (op)
            4'd1: begin e = 64'(sa * sb); exp_lat = 17; end
            4'd2: begin e = ua * ub; exp_lat = 17; end
            4'd3: begin e = hl + 64'(sa * sb); exp_lat = 17; end
            4'd4: begin e = hl + ua * ub; exp_lat = 17; end
            4'd5: begin e = hl - 64'(sa * sb); exp_lat = 17; end
            4'd6: begin e = hl - ua * ub; exp_lat = 17; end
            4'd7: if (b == 0) begin exp_lat = 0; exp_dbz = 1'b1; end
                  else begin e = {32'(sa % sb), 32'(sa / sb)}; exp_lat = 33; end
            4'd8: if (b == 0) begin exp_lat = 0; exp_dbz = 1'b1; end
                  else begin e = {32'(ua % ub), 32'(ua / ub)}; exp_lat = 33; end
            4'd9: e[63:32] = a;
            4'd10: e[31:0] = a;
            default: ;
        endcase
        issue(op, a, b);
        lat = 0;
        busy_n = 0;
        while (!md_done && lat < 40) begin
            busy_n += int'(md_busy);
            @(negedge clk);
            lat++;
        end
        if (exp_lat < 0) begin
            chk($sformatf("op%0d no_done", op), 64'(md_done), 64'(0));
            chk($sformatf("op%0d no_busy", op), 64'(busy_n), 64'(0));
        end else begin
            chk($sformatf("op%0d latency", op), 64'(lat), 64'(exp_lat));
            chk($sformatf("op%0d busy_cycles", op), 64'(busy_n), 64'(exp_lat));
            chk($sformatf("op%0d dbz", op), 64'(md_div_by_zero), 64'(exp_dbz));
            @(negedge clk);
            chk($sformatf("op%0d done_pulse", op), 64'(md_done), 64'(0));
        end
        chk($sformatf("op%0d hi", op), 64'(md_hi), 64'(e[63:32]));
        chk($sformatf("op%0d lo", op), 64'(md_lo), 64'(e[31:0]));
        {m_hi, m_lo} = e;
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return $urandom_range(0, 20);
            3: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction
    initial begin
        int lat, seen;
        logic [31:0] b;
        repeat (2) @(negedge clk);
        chk("reset_hi", 64'(md_hi), 64'(0));
        chk("reset_lo", 64'(md_lo), 64'(0));
        chk("reset_busy", 64'(md_busy), 64'(0));
        chk("reset_done", 64'(md_done), 64'(0));
        rst = 1'b0;
        do_op(4'd1, 32'hFFFF_FFFD, 32'd5);
        do_op(4'd9, 32'd0, 32'd0);
        do_op(4'd10, 32'hFFFF_FFFF, 32'd0);
        do_op(4'd4, 32'd1, 32'd1);
        do_op(4'd6, 32'd1, 32'd1);
        do_op(4'd7, 32'hFFFF_FFF9, 32'd2);
        do_op(4'd8, 32'd100, 32'd7);
        do_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(4'd10, 32'h1234, 32'd0);
        do_op(4'd8, 32'd9, 32'd0);
        do_op(4'd0, 32'd5, 32'd5);
        do_op(4'd13, 32'd5, 32'd5);
        // flush in the middle of a divide leaves HI/LO alone
        issue(4'd8, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        chk("flush_busy", 64'(md_busy), 64'(0));
        seen = 0;
        repeat (40) begin
            seen += int'(md_done);
            @(negedge clk);
        end
        chk("flush_no_done", 64'(seen), 64'(0));
        chk("flush_hilo", {md_hi, md_lo}, {m_hi, m_lo});
        @(negedge clk);
        md_start = 1'b1;
        md_flush = 1'b1;
        md_op = 4'd10;
        md_operand_a = 32'h5555;
        @(negedge clk);
        md_start = 1'b0;
        md_flush = 1'b0;
        chk("flush_start_lo", 64'(md_lo), 64'(m_lo));
        // start while busy is dropped
        issue(4'd2, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        md_start = 1'b1;
        md_op = 4'd10;
        md_operand_a = 32'hDEAD;
        @(negedge clk);
        md_start = 1'b0;
        lat = 4;
        while (!md_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ignored_start_latency", 64'(lat), 64'(17));
        chk("ignored_start_hi", 64'(md_hi), 64'(0));
        chk("ignored_start_lo", 64'(md_lo), 64'(42));
        {m_hi, m_lo} = {32'd0, 32'd42};
        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            do_op(4'($urandom_range(0, 15)), pick(), b);
        end
        // async reset between edges
        issue(4'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", 64'(md_hi), 64'(0));
        chk("arst_lo", 64'(md_lo), 64'(0));
        chk("arst_busy", 64'(md_busy), 64'(0));
        chk("arst_done", 64'(md_done), 64'(0));
        #1 rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            seen += int'(md_done);
        end
        chk("arst_no_done", 64'(seen), 64'(0));
        {m_hi, m_lo} = '0;
        do_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
